alu_decoder: RTL and testbench
==============================

// Module: alu_decoder
// PURPOSE
//  Main ALU control decoder of the single-cycle RV32I core. It sits between the main control decoder and the ALU.
//  It maps ALUOP, funct3, op5 (opcode bit 5) and funct7 to a 3-bit ALU operation code.
//  Decode is purely combinational with zero latency.
//  A clocked side path provides a registered copy of the code and a sticky flag for unsupported encodings.
// PARAMETERS
//  none (all widths fixed by the RV32I encoding)
// PORTS
//  clk           input   1  single clock; all state updates on rising edge
//  rst           input   1  synchronous, active-high reset
//  op5           input   1  instruction opcode bit 5 (1 = R-type, 0 = I-type ALU op)
//  ALUOP         input   2  class from main decoder: 00 load/store/add, 01 branch, 10 R/I-type, 11 reserved
//  funct3        input   3  instruction funct3 field
//  funct7        input   7  instruction funct7 field; only bit 5 is used
//  ALUControl    output  3  combinational ALU operation code
//  ALUControl_q  output  3  ALUControl registered on clk
//  illegal_op    output  1  sticky: an unsupported encoding was decoded
// BEHAVIOUR
//  Codes: 000 ADD, 010 SUB, 001 SLL, 100 XOR, 101 SRL, 110 OR, 111 AND.
//  ALUControl is a function of the current inputs only:
//   - ALUOP=00 -> 000, independent of all other inputs.
//   - ALUOP=01 -> 010, independent of all other inputs.
//   - ALUOP=10, decoded on funct3:
//     - 000: 010 if {op5,funct7[5]}==2'b11 (SUB); otherwise 000 (ADD/ADDI, including ADDI with funct7[5]=1).
//     - 001 -> 001; 100 -> 100; 101 -> 101 (funct7[5] ignored; no SRA); 110 -> 110; 111 -> 111.
//     - 010, 011 (SLT/SLTU, unsupported) -> 000.
//   - ALUOP=11 -> 000.
//  ALUControl is never X or Z for known inputs; use a full case with defaults.
//  funct7 bits other than 5 never affect any output.
//  rst has no effect on ALUControl; it is combinational and valid at all times.
//  ALUControl_q: on each rising clk edge, rst=1 loads 000; otherwise it loads the current ALUControl (1-cycle latency).
//  illegal_op: rst=1 clears it to 0 on the clock edge.
//   - Otherwise it sets to 1 on the clock edge when the current inputs are ALUOP=11, or ALUOP=10 with funct3 in {010,011}.
//   - Once set, it holds 1 until reset.
//   - If rst and an illegal encoding occur in the same cycle, reset wins and the flag is 0.
//  Reset values: ALUControl_q=000, illegal_op=0.
// TESTING
//  ALUOP=00, op5=1, funct7=7'h20, funct3=000 -> ALUControl=000; ALUOP=01 with funct3=111 -> 010.
//  ALUOP=10, funct3=000: {op5,funct7[5]}=11 -> 010. Cases 10, 01 and 00 -> 000.
//  ALUOP=10, funct3 = 001, 100, 101, 110, 111 -> ALUControl equals funct3; random funct7 has no effect.
//  ALUOP=10, funct3=010 -> ALUControl=000; the next clk sets illegal_op=1.
//   - illegal_op stays 1 after legal inputs; rst=1 for one edge clears it to 0.
//  ALUOP=11 -> ALUControl=000 and illegal_op set. Hold rst=1 with ALUOP=11 -> illegal_op stays 0.
//  Registered path: ALUOP=10, funct3=110 -> ALUControl_q=110 one edge later; rst=1 -> 000 on the next edge.
//  Random: 100+ vectors, each checked against the table after settling.

Source files
------------

// File: rtl/alu_decoder.sv
// ----------------------------------------------------------------------------
// alu_decoder
// ALU control decoder for a single-cycle RV32I core. It sits between the main
// control decoder and the ALU.
//
// The ALU operation code is decoded combinationally with zero latency. A
// clocked side path provides:
//   - a registered copy of the operation code;
//   - a sticky flag that records whether an unsupported encoding was decoded.
//
// Ports
//   clk           in   1  clock; all state updates on the rising edge
//   rst           in   1  synchronous active-high reset (registered path only)
//   op5           in   1  opcode bit 5 (1 = R-type, 0 = I-type ALU op)
//   ALUOP         in   2  class: 00 add, 01 branch, 10 R/I-type, 11 reserved
//   funct3        in   3  instruction funct3 field
//   funct7        in   7  instruction funct7 field (only bit 5 is used)
//   ALUControl    out  3  combinational ALU operation code
//   ALUControl_q  out  3  ALUControl registered on clk
//   illegal_op    out  1  sticky flag for unsupported encodings
//
// Operation codes
//   000 ADD   010 SUB   001 SLL   100 XOR   101 SRL   110 OR   111 AND
// ----------------------------------------------------------------------------
module alu_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       op5,
    input  logic [1:0] ALUOP,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [2:0] ALUControl,
    output logic [2:0] ALUControl_q,
    output logic       illegal_op
);

    logic [2:0] alu_control_s;
    logic       illegal_s;
    logic [2:0] alu_control_d;
    logic [2:0] alu_control_q;
    logic       illegal_op_d;
    logic       illegal_op_q;

    // Only funct7[5] distinguishes SUB from ADD. The other funct7 bits are
    // collected here so that they are visibly consumed and never reach any
    // output.
    logic       unused_funct7_s;
    assign unused_funct7_s = ^{funct7[6], funct7[4:0]};

    // Combinational decode of the ALU operation code and the illegal-encoding
    // indicator.
    always_comb begin
        alu_control_s = 3'b000;
        illegal_s     = 1'b0;
        case (ALUOP)
            2'b00: alu_control_s = 3'b000;
            2'b01: alu_control_s = 3'b010;
            2'b10: begin
                case (funct3)
                    3'b000: begin
                        // SUB only for R-type with funct7[5] set. ADDI ignores
                        // funct7[5], because those bits belong to its immediate.
                        if ({op5, funct7[5]} == 2'b11) begin
                            alu_control_s = 3'b010;
                        end else begin
                            alu_control_s = 3'b000;
                        end
                    end
                    3'b001: alu_control_s = 3'b001;
                    3'b100: alu_control_s = 3'b100;
                    3'b101: alu_control_s = 3'b101; // SRA is not supported
                    3'b110: alu_control_s = 3'b110;
                    3'b111: alu_control_s = 3'b111;
                    3'b010, 3'b011: begin
                        // Set-less-than encodings decode to ADD and raise the flag.
                        alu_control_s = 3'b000;
                        illegal_s     = 1'b1;
                    end
                    default: alu_control_s = 3'b000;
                endcase
            end
            2'b11: begin
                alu_control_s = 3'b000;
                illegal_s     = 1'b1;
            end
            default: begin
                alu_control_s = 3'b000;
                illegal_s     = 1'b0;
            end
        endcase
    end

    // Next-state values for the registered code and the sticky illegal flag.
    always_comb begin
        alu_control_d = alu_control_s;
        illegal_op_d  = illegal_op_q | illegal_s;
    end

    // State registers. The synchronous reset has priority over a
    // same-cycle illegal encoding.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_control_q <= 3'b000;
            illegal_op_q  <= 1'b0;
        end else begin
            alu_control_q <= alu_control_d;
            illegal_op_q  <= illegal_op_d;
        end
    end

    assign ALUControl   = alu_control_s;
    assign ALUControl_q = alu_control_q;
    assign illegal_op   = illegal_op_q;

endmodule

// File: tb/tb_alu_decoder.sv
// ----------------------------------------------------------------------------
// tb_alu_decoder
// Self-checking bench for alu_decoder. The stimulus has three parts:
//   - a table of legal vectors with hand-derived codes;
//   - hand sequences for the sticky flag and the reset corners;
//   - a randomized run compared against a rule-level reference model.
// ----------------------------------------------------------------------------
module tb_alu_decoder;

    logic       clk;
    logic       rst;
    logic       op5;
    logic [1:0] ALUOP;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [2:0] ALUControl;
    logic [2:0] ALUControl_q;
    logic       illegal_op;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state of the clocked path.
    logic [2:0] exp_q;
    logic       exp_ill;

    alu_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .op5         (op5),
        .ALUOP       (ALUOP),
        .funct3      (funct3),
        .funct7      (funct7),
        .ALUControl  (ALUControl),
        .ALUControl_q(ALUControl_q),
        .illegal_op  (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so that the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach its end (actual running, required finished)");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [1:0] aluop;
        logic [2:0] f3;
        logic       o5;
        logic [6:0] f7;
        logic [2:0] exp_ctl;
    } vec_t;

    vec_t tbl [14];

    // Reference model, written directly from the decoding rules.
    function automatic logic [2:0] ref_ctl(input logic [1:0] a, input logic [2:0] f3,
                                           input logic o5, input logic [6:0] f7);
        if (a == 2'd0) return 3'd0;
        if (a == 2'd1) return 3'd2;
        if (a == 2'd3) return 3'd0;
        if (f3 == 3'd0) return (o5 && f7[5]) ? 3'd2 : 3'd0;
        if (f3 == 3'd2 || f3 == 3'd3) return 3'd0;
        return f3;
    endfunction

    function automatic logic ref_ill(input logic [1:0] a, input logic [2:0] f3);
        return (a == 2'd3) || (a == 2'd2 && (f3 == 3'd2 || f3 == 3'd3));
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual %b required %b (ALUOP=%b funct3=%b op5=%b funct7=%h rst=%b)",
                     name, act, req, ALUOP, funct3, op5, funct7, rst);
        end
    endtask

    // Apply one set of inputs for one clock cycle. The combinational output is
    // checked before the edge; the registered outputs are checked just after it.
    task automatic apply(input string name, input logic r, input logic [1:0] a,
                         input logic [2:0] f3, input logic o5, input logic [6:0] f7,
                         input logic [2:0] exp_ctl);
        rst = r; ALUOP = a; funct3 = f3; op5 = o5; funct7 = f7;
        #1;
        check({name, ".ctl"}, ALUControl, exp_ctl);
        @(posedge clk);
        if (r) begin
            exp_q   = 3'd0;
            exp_ill = 1'b0;
        end else begin
            exp_q   = exp_ctl;
            exp_ill = exp_ill | ref_ill(a, f3);
        end
        #1;
        check({name, ".q"}, ALUControl_q, exp_q);
        check({name, ".ill"}, {2'b00, illegal_op}, {2'b00, exp_ill});
    endtask

    initial begin
        tbl[0]  = '{2'b00, 3'b000, 1'b1, 7'h20, 3'b000};
        tbl[1]  = '{2'b01, 3'b111, 1'b0, 7'h00, 3'b010};
        tbl[2]  = '{2'b10, 3'b000, 1'b1, 7'h20, 3'b010};
        tbl[3]  = '{2'b10, 3'b000, 1'b1, 7'h00, 3'b000};
        tbl[4]  = '{2'b10, 3'b000, 1'b0, 7'h20, 3'b000};
        tbl[5]  = '{2'b10, 3'b000, 1'b0, 7'h00, 3'b000};
        tbl[6]  = '{2'b10, 3'b001, 1'b1, 7'h7f, 3'b001};
        tbl[7]  = '{2'b10, 3'b100, 1'b0, 7'h5a, 3'b100};
        tbl[8]  = '{2'b10, 3'b101, 1'b1, 7'h20, 3'b101};
        tbl[9]  = '{2'b10, 3'b110, 1'b0, 7'h20, 3'b110};
        tbl[10] = '{2'b10, 3'b111, 1'b1, 7'h7f, 3'b111};
        tbl[11] = '{2'b00, 3'b101, 1'b1, 7'h5f, 3'b000};
        tbl[12] = '{2'b01, 3'b000, 1'b0, 7'h20, 3'b010};
        tbl[13] = '{2'b10, 3'b000, 1'b1, 7'h5f, 3'b000};

        // Reset: drive illegal inputs while rst is held.
        rst = 1'b1; ALUOP = 2'b11; funct3 = 3'b000; op5 = 1'b0; funct7 = 7'h00;
        exp_q = 3'd0; exp_ill = 1'b0;
        @(posedge clk);
        #1;
        check("reset.q", ALUControl_q, 3'b000);
        check("reset.ill", {2'b00, illegal_op}, 3'b000);

        // Legal table vectors.
        for (int i = 0; i < 14; i++) begin
            apply($sformatf("tbl%0d", i), 1'b0, tbl[i].aluop, tbl[i].f3,
                  tbl[i].o5, tbl[i].f7, tbl[i].exp_ctl);
        end

        // Sticky flag: an unsupported funct3 sets it, legal inputs keep it set,
        // and one reset edge clears it.
        apply("slt",       1'b0, 2'b10, 3'b010, 1'b1, 7'h00, 3'b000);
        apply("sticky",    1'b0, 2'b10, 3'b110, 1'b0, 7'h00, 3'b110);
        apply("sticky2",   1'b0, 2'b00, 3'b000, 1'b0, 7'h00, 3'b000);
        apply("clr",       1'b1, 2'b10, 3'b110, 1'b0, 7'h00, 3'b110);
        apply("sltu",      1'b0, 2'b10, 3'b011, 1'b0, 7'h20, 3'b000);
        apply("clr2",      1'b1, 2'b00, 3'b000, 1'b0, 7'h00, 3'b000);

        // Reserved ALUOP sets the flag; holding reset with it keeps the flag clear.
        apply("rsvd",      1'b0, 2'b11, 3'b111, 1'b1, 7'h7f, 3'b000);
        apply("rsvd_rst0", 1'b1, 2'b11, 3'b010, 1'b1, 7'h20, 3'b000);
        apply("rsvd_rst1", 1'b1, 2'b11, 3'b111, 1'b0, 7'h00, 3'b000);

        // Registered path: OR code one edge later, then reset loads ADD.
        apply("regpath",   1'b0, 2'b10, 3'b110, 1'b0, 7'h00, 3'b110);
        apply("regrst",    1'b1, 2'b10, 3'b110, 1'b0, 7'h00, 3'b110);

        // Randomized run with occasional reset.
        for (int i = 0; i < 200; i++) begin
            logic       r;
            logic [1:0] a;
            logic [2:0] f3;
            logic       o5;
            logic [6:0] f7;
            r  = ($urandom_range(0, 9) == 0);
            a  = 2'($urandom_range(0, 3));
            f3 = 3'($urandom_range(0, 7));
            o5 = 1'($urandom_range(0, 1));
            f7 = 7'($urandom_range(0, 127));
            apply("rand", r, a, f3, o5, f7, ref_ctl(a, f3, o5, f7));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
